instruction_fetch_unit: RTL and testbench

- Parametrised, loadable instruction store with a built-in program counter and a registered valid/ready fetch interface.
- Replaces the fixed 8-entry, combinationally addressed instruction ROM:
  - the program is written through a load port while the unit is idle;
  - the unit then steps through the program itself, one instruction per accepted handshake;
  - it supports jumps, stall, stop and optional end-of-program termination.
- Sits between the program-load path (switches/host) and the decode/control stage of the course-project CPU.

---
 rtl/instruction_fetch_unit_if.sv | 14 +
 rtl/instruction_fetch_unit.sv | 75 +++++++
 tb/tb_instruction_fetch_unit.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_if.sv
// instruction_fetch_unit_if: fetch-side handshake bundle between the fetch unit and decode
interface instruction_fetch_unit_if #(
  parameter int INSTR_W = 12,
  parameter int ADDR_W  = 3
);
  logic [INSTR_W-1:0] instr_out;
  logic [ADDR_W-1:0]  pc_out;
  logic               instr_valid;
  logic               out_ready;
  logic               jump_en;
  logic [ADDR_W-1:0]  jump_addr;
  modport master (output instr_out, pc_out, instr_valid, input out_ready, jump_en, jump_addr);
  modport slave  (input instr_out, pc_out, instr_valid, output out_ready, jump_en, jump_addr);
endinterface

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: loadable instruction store with its own PC and a registered valid/ready fetch port
module instruction_fetch_unit #(
  parameter int INSTR_W = 12,
  parameter int DEPTH   = 8,
  parameter int ADDR_W  = $clog2(DEPTH),
  parameter int WRAP    = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_load_en,
  input  logic [ADDR_W-1:0]       i_load_addr,
  input  logic [INSTR_W-1:0]      i_load_data,
  input  logic                    i_start,
  input  logic                    i_stop,
  instruction_fetch_unit_if.master bus,
  output logic                    o_busy,
  output logic                    o_done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t             r_state;
  logic [INSTR_W-1:0] r_mem [DEPTH] = '{default: '0};
  logic [INSTR_W-1:0] r_instr;
  logic [ADDR_W-1:0]  r_pc;
  logic               r_valid;
  logic [ADDR_W-1:0]  w_next;
  logic               w_hs;
  logic               w_end;
  assign w_hs   = r_valid & bus.out_ready;
  assign w_next = bus.jump_en ? bus.jump_addr : r_pc + ADDR_W'(1);
  assign w_end  = (WRAP == 0) && !bus.jump_en && (r_pc == ADDR_W'(DEPTH - 1));
  // program store: writable only while not fetching, survives reset
  always_ff @(posedge clk)
    if (i_load_en && r_state != RUN) r_mem[i_load_addr] <= i_load_data;
  // fetch sequencer: stop beats handshake, a load alongside start suppresses the start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_pc    <= '0;
      r_instr <= '0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (i_stop) begin
            r_state <= IDLE;
            r_pc    <= '0;
            r_valid <= 1'b0;
          end else if (w_hs && w_end) begin
            r_state <= DONE;
            r_valid <= 1'b0;
          end else if (w_hs) begin
            r_pc    <= w_next;
            r_instr <= r_mem[w_next];
          end
        end
        default: begin
          if (i_start && !i_load_en) begin
            r_state <= RUN;
            r_pc    <= '0;
            r_instr <= r_mem[0];
            r_valid <= 1'b1;
          end else if (i_stop) begin
            r_state <= IDLE;
            r_pc    <= '0;
          end
        end
      endcase
    end
  end
  assign bus.instr_out   = r_instr;
  assign bus.pc_out      = r_pc;
  assign bus.instr_valid = r_valid;
  assign o_busy          = r_state == RUN;
  assign o_done          = r_state == DONE;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed plus random checks of a wrapping and a terminating fetch unit against a spec-level model
module tb_instruction_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_en = 1'b0;
  logic [2:0]  load_addr = '0;
  logic [11:0] load_data = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        out_ready = 1'b0;
  logic        jump_en = 1'b0;
  logic [2:0]  jump_addr = '0;
  logic        busy0, done0, busy1, done1;
  int          errs = 0;
  int          checks = 0;
  int          ms [2];
  int          mpc [2];
  int          mins [2];
  bit          mval [2];
  int          mm [2][8];

  instruction_fetch_unit_if #(.INSTR_W(12), .ADDR_W(3)) b0 ();
  instruction_fetch_unit_if #(.INSTR_W(12), .ADDR_W(3)) b1 ();
  assign b0.out_ready = out_ready;
  assign b0.jump_en   = jump_en;
  assign b0.jump_addr = jump_addr;
  assign b1.out_ready = out_ready;
  assign b1.jump_en   = jump_en;
  assign b1.jump_addr = jump_addr;

  instruction_fetch_unit #(.INSTR_W(12), .DEPTH(8), .WRAP(1)) u_wrap (
    .clk(clk), .rst_n(rst_n), .i_load_en(load_en), .i_load_addr(load_addr),
    .i_load_data(load_data), .i_start(start), .i_stop(stop), .bus(b0),
    .o_busy(busy0), .o_done(done0));
  instruction_fetch_unit #(.INSTR_W(12), .DEPTH(8), .WRAP(0)) u_end (
    .clk(clk), .rst_n(rst_n), .i_load_en(load_en), .i_load_addr(load_addr),
    .i_load_data(load_data), .i_start(start), .i_stop(stop), .bus(b1),
    .o_busy(busy1), .o_done(done1));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // model states: 0 idle, 1 fetching, 2 program ended
  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      ms[k] = 0; mpc[k] = 0; mins[k] = 0; mval[k] = 0;
    end
  endtask

  task automatic model_step();
    int nx;
    for (int k = 0; k < 2; k++) begin
      if (ms[k] == 1) begin
        if (stop) begin
          ms[k] = 0; mpc[k] = 0; mval[k] = 0;
        end else if (mval[k] && out_ready) begin
          nx = jump_en ? int'(jump_addr) : (mpc[k] + 1) % 8;
          if (k == 1 && !jump_en && mpc[k] == 7) begin
            ms[k] = 2; mval[k] = 0;
          end else begin
            mpc[k] = nx; mins[k] = mm[k][nx];
          end
        end
      end else begin
        if (start && !load_en) begin
          ms[k] = 1; mpc[k] = 0; mins[k] = mm[k][0]; mval[k] = 1;
        end else if (stop) begin
          ms[k] = 0; mpc[k] = 0;
        end
        if (load_en) mm[k][load_addr] = int'(load_data);
      end
    end
  endtask

  task automatic check_all();
    chk("wrap.pc", 32'(b0.pc_out), 32'(mpc[0]));
    chk("wrap.valid", 32'(b0.instr_valid), 32'(mval[0]));
    chk("wrap.busy", 32'(busy0), 32'(ms[0] == 1));
    chk("wrap.done", 32'(done0), 32'(ms[0] == 2));
    if (mval[0]) chk("wrap.instr", 32'(b0.instr_out), 32'(mins[0]));
    chk("end.pc", 32'(b1.pc_out), 32'(mpc[1]));
    chk("end.valid", 32'(b1.instr_valid), 32'(mval[1]));
    chk("end.busy", 32'(busy1), 32'(ms[1] == 1));
    chk("end.done", 32'(done1), 32'(ms[1] == 2));
    if (mval[1]) chk("end.instr", 32'(b1.instr_out), 32'(mins[1]));
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
    check_all();
  endtask

  task automatic check_reset_outputs();
    chk("rst.wrap.instr", 32'(b0.instr_out), 0);
    chk("rst.end.instr", 32'(b1.instr_out), 0);
    check_all();
  endtask

  initial begin
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < 8; a++) mm[k][a] = 0;
    model_reset();
    #2;
    check_reset_outputs();
    repeat (2) cyc();
    rst_n = 1'b1;
    repeat (3) cyc();
    // untouched memory reads as zero
    start = 1'b1; cyc(); start = 1'b0;
    chk("zero_mem", 32'(b0.instr_out), 0);
    stop = 1'b1; cyc(); stop = 1'b0;
    // load program then start on the very next cycle
    for (int i = 0; i < 8; i++) begin
      load_en = 1'b1; load_addr = 3'(i); load_data = 12'(12'h100 + i); cyc();
    end
    load_en = 1'b0; start = 1'b1; cyc(); start = 1'b0;
    chk("first_fetch", 32'(b0.instr_out), 32'h100);
    out_ready = 1'b1;
    repeat (9) cyc();
    chk("wrapped_pc", 32'(b0.pc_out), 1);
    stop = 1'b1; cyc(); stop = 1'b0;
    // stall at pc 3 with a jump request that must be ignored
    start = 1'b1; cyc(); start = 1'b0;
    repeat (3) cyc();
    out_ready = 1'b0; jump_en = 1'b1; jump_addr = 3'd5;
    repeat (4) cyc();
    chk("stall.pc", 32'(b0.pc_out), 3);
    chk("stall.instr", 32'(b0.instr_out), 32'h103);
    jump_en = 1'b0; out_ready = 1'b1; cyc();
    chk("after_stall", 32'(b0.instr_out), 32'h104);
    // jump from pc 2 to 6, then walk off the end
    stop = 1'b1; cyc(); stop = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    repeat (2) cyc();
    jump_en = 1'b1; jump_addr = 3'd6; cyc(); jump_en = 1'b0;
    chk("jump.instr", 32'(b0.instr_out), 32'h106);
    cyc();
    cyc();
    chk("end.done_flag", 32'(done1), 1);
    start = 1'b1; cyc(); start = 1'b0;
    chk("restart.instr", 32'(b1.instr_out), 32'h100);
    // stop outranks handshake and jump
    jump_en = 1'b1; jump_addr = 3'd5; stop = 1'b1; cyc(); stop = 1'b0; jump_en = 1'b0;
    // load during RUN must not land
    start = 1'b1; cyc(); start = 1'b0;
    out_ready = 1'b0; load_en = 1'b1; load_addr = 3'd1; load_data = 12'hABC; cyc();
    load_en = 1'b0; out_ready = 1'b1; cyc();
    chk("run_load_ignored", 32'(b0.instr_out), 32'h101);
    stop = 1'b1; cyc(); stop = 1'b0;
    // start with load in IDLE: write lands, start ignored
    load_en = 1'b1; start = 1'b1; load_addr = 3'd2; load_data = 12'h222; cyc();
    chk("start_with_load", 32'(busy0), 0);
    load_en = 1'b0; cyc(); start = 1'b0;
    repeat (2) cyc();
    chk("idle_load_landed", 32'(b0.instr_out), 32'h222);
    // asynchronous reset in the middle of RUN
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_reset_outputs();
    repeat (2) cyc();
    #3 rst_n = 1'b1;
    cyc();
    // random traffic
    for (int n = 0; n < 400; n++) begin
      load_en   = ($urandom % 4) == 0;
      load_addr = 3'($urandom);
      load_data = 12'($urandom);
      start     = ($urandom % 8) == 0;
      stop      = ($urandom % 16) == 0;
      jump_en   = ($urandom % 4) == 0;
      jump_addr = 3'($urandom);
      out_ready = ($urandom % 4) != 0;
      cyc();
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
